// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: holds the PC, advances it on each
// fetch handshake, takes branch/jump redirects and traps misaligned targets.
module pc_unit #(
  parameter int unsigned     XLEN         = 64,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            redirect_vld,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Low-address bits that must be clear; an all-zero mask when ALIGN_BITS is 0.
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} >> (XLEN - ALIGN_BITS);

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr & ALIGN_MASK) == {XLEN{1'b0}};
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic            misalign_r;
  logic            misalign_nxt_s;
  logic            redir_ok_s;
  logic [XLEN-1:0] redir_tgt_s;

  assign pc_next_seq  = pc_r + XLEN'(INC);
  assign pc_out       = pc_r;
  assign misalign_err = misalign_r;
  assign pc_valid     = (state_r == ST_RUN);
  assign halted       = (state_r == ST_HALT);

  // Redirect target after the alignment check.
  always_comb begin
    redir_ok_s  = is_aligned(redirect_pc);
    redir_tgt_s = TRAP_VECTOR;
    if (redir_ok_s) begin
      redir_tgt_s = redirect_pc;
    end else begin
      redir_tgt_s = TRAP_VECTOR;
    end
  end

  // Next-state and next-PC selection: redirect beats sequential advance beats hold.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    misalign_nxt_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_vld) begin
          pc_nxt_s       = redir_tgt_s;
          misalign_nxt_s = !redir_ok_s;
        end else if (fetch_ready) begin
          pc_nxt_s = pc_next_seq;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        // A redirect while halted becomes the first PC issued after resume.
        if (redirect_vld) begin
          pc_nxt_s       = redir_tgt_s;
          misalign_nxt_s = !redir_ok_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (resume && !halt_req) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
        pc_nxt_s    = RESET_VECTOR;
      end
    endcase
  end

  // State, PC and error-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_VECTOR;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 64-bit default instance and an 8-bit wrap instance with
// the alignment check disabled, both checked against a spec-level model.
module tb_pc_unit;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fetch_ready, redirect_vld, halt_req, resume;
  logic [63:0] redirect_pc;
  logic [63:0] pc_out, pc_next_seq;
  logic        pc_valid, misalign_err, halted;

  logic        fetch_ready_b, redirect_vld_b, halt_req_b, resume_b;
  logic [7:0]  redirect_pc_b;
  logic [7:0]  pc_out_b, pc_next_seq_b;
  logic        pc_valid_b, misalign_err_b, halted_b;

  pc_unit dut_a (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .resume(resume), .pc_out(pc_out),
    .pc_next_seq(pc_next_seq), .pc_valid(pc_valid), .misalign_err(misalign_err), .halted(halted)
  );

  pc_unit #(.XLEN(8), .INC(4), .ALIGN_BITS(0), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h10)) dut_b (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready_b), .redirect_vld(redirect_vld_b),
    .redirect_pc(redirect_pc_b), .halt_req(halt_req_b), .resume(resume_b), .pc_out(pc_out_b),
    .pc_next_seq(pc_next_seq_b), .pc_valid(pc_valid_b), .misalign_err(misalign_err_b), .halted(halted_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] ma_pc, mb_pc;
  int          ma_mode, mb_mode;
  bit          ma_mis, mb_mis;

  wire [130:0] act_a = {pc_out, pc_next_seq, pc_valid, misalign_err, halted};
  wire [18:0]  act_b = {pc_out_b, pc_next_seq_b, pc_valid_b, misalign_err_b, halted_b};

  function automatic logic [130:0] exp_a();
    return {ma_pc, ma_pc + 64'd4, ma_mode == M_RUN, ma_mis, ma_mode == M_HALT};
  endfunction

  function automatic logic [18:0] exp_b();
    logic [63:0] nx;
    nx = mb_pc + 64'd4;
    return {mb_pc[7:0], nx[7:0], mb_mode == M_RUN, mb_mis, mb_mode == M_HALT};
  endfunction

  // One clock edge of the behavioural PC unit.
  task automatic model_step(inout logic [63:0] pc, inout int mode, inout bit mis,
                            input bit fr, input bit rv, input logic [63:0] rpc,
                            input bit hr, input bit rs, input int abits,
                            input logic [63:0] trap, input logic [63:0] mask);
    mis = 1'b0;
    if (mode == M_BOOT) begin
      mode = M_RUN;
    end else begin
      if (rv) begin
        if ((rpc % (64'd1 << abits)) != 64'd0) begin
          pc  = trap;
          mis = 1'b1;
        end else begin
          pc = rpc;
        end
      end else if (mode == M_RUN && fr) begin
        pc = (pc + 64'd4) & mask;
      end
      if (mode == M_RUN && hr) mode = M_HALT;
      else if (mode == M_HALT && rs && !hr) mode = M_RUN;
    end
  endtask

  task automatic model_reset();
    ma_pc = 64'd0;  ma_mode = M_BOOT; ma_mis = 1'b0;
    mb_pc = 64'hF8; mb_mode = M_BOOT; mb_mis = 1'b0;
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b0; redirect_vld = 1'b0; redirect_pc = 64'd0; halt_req = 1'b0; resume = 1'b0;
    fetch_ready_b = 1'b0; redirect_vld_b = 1'b0; redirect_pc_b = 8'd0; halt_req_b = 1'b0; resume_b = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(ma_pc, ma_mode, ma_mis, fetch_ready, redirect_vld, redirect_pc,
               halt_req, resume, 2, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF);
    model_step(mb_pc, mb_mode, mb_mis, fetch_ready_b, redirect_vld_b, {56'd0, redirect_pc_b},
               halt_req_b, resume_b, 0, 64'h10, 64'hFF);
    #1;
  endtask

  // Pulse reset between edges, then release it before the next edge.
  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    #2;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'd0) begin
      n_fail++; $display("FAIL reset_a: got %h expected %h", act_a, exp_a());
    end
    n_tests++;
    if (act_b !== exp_b()) begin
      n_fail++; $display("FAIL reset_b: got %h expected %h", act_b, exp_b());
    end
    #3;
    reset = 1'b1;
  endtask

  task automatic test_boot_count();
    logic [63:0] seq [3];
    seq[0] = 64'd0; seq[1] = 64'd4; seq[2] = 64'd8;
    fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (act_a !== exp_a() || pc_out !== seq[i] || pc_valid !== 1'b1) begin
        n_fail++; $display("FAIL boot_count[%0d]: got %h expected pc %h / %h", i, act_a, seq[i], exp_a());
      end
    end
  endtask

  task automatic test_stall();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (act_a !== exp_a() || pc_out !== 64'd8 || pc_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall[%0d]: got %h expected %h", i, act_a, exp_a());
      end
    end
    fetch_ready = 1'b1;
    tick();
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'd12) begin
      n_fail++; $display("FAIL stall_resume: got %h expected %h", act_a, exp_a());
    end
  endtask

  task automatic test_redirect();
    fetch_ready = 1'b0; redirect_vld = 1'b1; redirect_pc = 64'h2000;
    tick();
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'h2000 || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL redirect_aligned: got %h expected %h", act_a, exp_a());
    end
    redirect_pc = 64'h2002;
    tick();
    redirect_vld = 1'b0;
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'h100 || misalign_err !== 1'b1) begin
      n_fail++; $display("FAIL redirect_misaligned: got %h expected %h", act_a, exp_a());
    end
    tick();
    n_tests++;
    if (act_a !== exp_a() || misalign_err !== 1'b0 || pc_out !== 64'h100) begin
      n_fail++; $display("FAIL misalign_pulse_len: got %h expected %h", act_a, exp_a());
    end
  endtask

  task automatic test_boot_ignores();
    idle_inputs();
    pulse_reset();
    redirect_vld = 1'b1; redirect_pc = 64'h2000; halt_req = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'd0 || halted !== 1'b0 || pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL boot_ignores: got %h expected %h", act_a, exp_a());
    end
  endtask

  task automatic test_halt();
    redirect_vld = 1'b1; redirect_pc = 64'h10;
    tick();
    redirect_vld = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0; fetch_ready = 1'b1;
    n_tests++;
    if (act_a !== exp_a() || halted !== 1'b1 || pc_valid !== 1'b0 || pc_out !== 64'h10) begin
      n_fail++; $display("FAIL halt_enter: got %h expected %h", act_a, exp_a());
    end
    tick(); tick();
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'h10 || pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_hold: got %h expected %h", act_a, exp_a());
    end
    redirect_vld = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_vld = 1'b0; resume = 1'b1;
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'h40 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_redirect: got %h expected %h", act_a, exp_a());
    end
    tick();
    resume = 1'b0;
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'h40 || pc_valid !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_resume: got %h expected %h", act_a, exp_a());
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    reset = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'd0 || halted !== 1'b0 || pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_halt: got %h expected %h", act_a, exp_a());
    end
    reset = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_redirect_with_halt();
    redirect_vld = 1'b1; redirect_pc = 64'h80; halt_req = 1'b1;
    tick();
    redirect_vld = 1'b0; resume = 1'b1;
    n_tests++;
    if (act_a !== exp_a() || pc_out !== 64'h80 || halted !== 1'b1) begin
      n_fail++; $display("FAIL redirect_and_halt: got %h expected %h", act_a, exp_a());
    end
    tick();
    n_tests++;
    if (act_a !== exp_a() || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_beats_resume: got %h expected %h", act_a, exp_a());
    end
    halt_req = 1'b0;
    tick();
    resume = 1'b0;
    n_tests++;
    if (act_a !== exp_a() || pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL resume_after_tie: got %h expected %h", act_a, exp_a());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    seq[0] = 8'hF8; seq[1] = 8'hFC; seq[2] = 8'h00; seq[3] = 8'h04;
    idle_inputs();
    pulse_reset();
    fetch_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (act_b !== exp_b() || pc_out_b !== seq[i] || misalign_err_b !== 1'b0) begin
        n_fail++; $display("FAIL wrap[%0d]: got %h expected pc %h / %h", i, act_b, seq[i], exp_b());
      end
    end
    redirect_vld_b = 1'b1; redirect_pc_b = 8'h33;
    tick();
    redirect_vld_b = 1'b0;
    n_tests++;
    if (act_b !== exp_b() || pc_out_b !== 8'h33 || misalign_err_b !== 1'b0) begin
      n_fail++; $display("FAIL no_align_check: got %h expected %h", act_b, exp_b());
    end
  endtask

  task automatic test_random();
    idle_inputs();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      fetch_ready  = ($urandom_range(0, 3) != 0);
      redirect_vld = ($urandom_range(0, 5) == 0);
      redirect_pc  = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0) redirect_pc = {60'hFFF_FFFF_FFFF_FFFF, redirect_pc[3:0]};
      halt_req     = ($urandom_range(0, 12) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      fetch_ready_b  = ($urandom_range(0, 3) != 0);
      redirect_vld_b = ($urandom_range(0, 7) == 0);
      redirect_pc_b  = 8'($urandom());
      halt_req_b     = ($urandom_range(0, 12) == 0);
      resume_b       = ($urandom_range(0, 3) == 0);
      tick();
      n_tests++;
      if (act_a !== exp_a()) begin
        n_fail++; $display("FAIL random_a[%0d]: got %h expected %h", i, act_a, exp_a());
      end
      n_tests++;
      if (act_b !== exp_b()) begin
        n_fail++; $display("FAIL random_b[%0d]: got %h expected %h", i, act_b, exp_b());
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    idle_inputs();
    test_reset();
    test_boot_count();
    test_stall();
    test_redirect();
    test_boot_ignores();
    test_halt();
    test_redirect_with_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
